// File: rtl/dma_slave_if.sv
// Request/response bus between a DMA master port and the slave model.
interface dma_slave_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) ();
  logic [ADDR_W-1:0] slave_addr;
  logic              slave_en;
  logic [1:0]        slave_wen;
  logic [DATA_W-1:0] slave_din;
  logic              slave_ready;
  logic [DATA_W-1:0] slave_dout;
  logic              slave_resp;

  modport master (
    output slave_addr, slave_en, slave_wen, slave_din,
    input  slave_ready, slave_dout, slave_resp
  );

  modport slave (
    input  slave_addr, slave_en, slave_wen, slave_din,
    output slave_ready, slave_dout, slave_resp
  );
endinterface

// File: rtl/dma_slave_model.sv
// Bus-slave model for the DMA bench: windowed word memory with byte-lane writes,
// fixed or LFSR-driven wait states, transaction counters and a protocol-violation flag.
module dma_slave_model #(
  parameter int unsigned       ADDR_W       = 16,
  parameter int unsigned       DATA_W       = 16,
  parameter int unsigned       DEPTH        = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int unsigned       WAIT_MODE    = 0,
  parameter int unsigned       WAIT_CYCLES  = 0,
  parameter int unsigned       MAX_WAIT     = 7,
  parameter logic [15:0]       LFSR_SEED    = 16'hACE1,
  parameter int unsigned       INIT_PATTERN = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  dma_slave_if.slave   bus,
  output logic [15:0]  rd_cnt,
  output logic [15:0]  wr_cnt,
  output logic [15:0]  err_cnt,
  output logic         proto_err
);

  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LFSR_K = $clog2(MAX_WAIT + 1);
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned OFF_W  = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d, load_cnt_c;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          wen_q, wen_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [15:0]         lfsr_q;
  logic                accept_c, pviol_c, commit_c;
  logic [OFF_W-1:0]    off_c;
  logic                hit_c, is_wr_c, mem_we_c;
  logic [IDX_W-1:0]    idx_c;
  logic [DATA_W-1:0]   rd_word_c, wr_word_c;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  // Power-up image of word i.
  function automatic logic [DATA_W-1:0] image_word(input logic [IDX_W-1:0] i);
    if (INIT_PATTERN != 0) return DATA_W'({1'b0, BASE_ADDR} + OFF_W'(i));
    return '0;
  endfunction

  assign load_cnt_c = (WAIT_MODE != 0) ? CNT_W'(lfsr_q[LFSR_K-1:0]) : CNT_W'(WAIT_CYCLES);

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    accept_c = 1'b0;
    pviol_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.slave_en) begin
          accept_c = 1'b1;
          wcnt_d   = load_cnt_c;
          state_d  = (load_cnt_c == '0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        pviol_c = !bus.slave_en;
        if (wcnt_q <= CNT_W'(1)) state_d = S_DONE;
        else                     wcnt_d  = wcnt_q - CNT_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request fields as they will be held during the transfer, valid on the accept cycle too.
  assign addr_d   = accept_c ? bus.slave_addr : addr_q;
  assign wen_d    = accept_c ? bus.slave_wen  : wen_q;
  assign din_d    = accept_c ? bus.slave_din  : din_q;
  assign commit_c = (state_d == S_DONE);

  // Decode in ADDR_W+1 bits so windows near the top of the map do not wrap.
  assign off_c     = {1'b0, addr_d} - {1'b0, BASE_ADDR};
  assign hit_c     = (addr_d >= BASE_ADDR) && (off_c < OFF_W'(DEPTH));
  assign idx_c     = off_c[IDX_W-1:0];
  assign is_wr_c   = |wen_d;
  assign rd_word_c = mem_q[idx_c] ^ image_word(idx_c);
  assign wr_word_c = {wen_d[1] ? din_d[15:8] : rd_word_c[15:8],
                      wen_d[0] ? din_d[7:0]  : rd_word_c[7:0]};
  assign mem_we_c  = commit_c && hit_c && is_wr_c && reset_n;

  // Storage holds each word XORed with its power-up image, so a cleared array reads as the image.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[idx_c] <= wr_word_c ^ image_word(idx_c);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      wcnt_q          <= '0;
      addr_q          <= '0;
      wen_q           <= '0;
      din_q           <= '0;
      lfsr_q          <= LFSR_SEED;
      bus.slave_ready <= 1'b0;
      bus.slave_dout  <= '0;
      bus.slave_resp  <= 1'b0;
      rd_cnt          <= '0;
      wr_cnt          <= '0;
      err_cnt         <= '0;
      proto_err       <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      din_q   <= din_d;
      if (accept_c) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      bus.slave_ready <= commit_c;
      bus.slave_dout  <= (commit_c && hit_c && !is_wr_c) ? rd_word_c : '0;
      bus.slave_resp  <= commit_c && !hit_c;
      if (commit_c && hit_c && !is_wr_c) rd_cnt  <= rd_cnt + 16'd1;
      if (commit_c && hit_c &&  is_wr_c) wr_cnt  <= wr_cnt + 16'd1;
      if (commit_c && !hit_c)            err_cnt <= err_cnt + 16'd1;
      proto_err <= proto_err | pviol_c;
    end
  end

endmodule

// File: tb/tb_dma_slave_model.sv
// Directed bench for dma_slave_model: five instances with different wait/window setups
// share one request bus; sel picks which one sees slave_en.
module tb_dma_slave_model;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic [1:0]  wen;
  logic [15:0] addr, din;
  logic [2:0]  sel;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dma_slave_if #(.ADDR_W(16), .DATA_W(16)) if_fix ();
  dma_slave_if #(.ADDR_W(16), .DATA_W(16)) if_zero ();
  dma_slave_if #(.ADDR_W(16), .DATA_W(16)) if_win ();
  dma_slave_if #(.ADDR_W(16), .DATA_W(16)) if_rnd ();
  dma_slave_if #(.ADDR_W(16), .DATA_W(16)) if_pv ();

  wire [4:0]        rdy;
  wire [4:0]        rsp;
  wire [4:0][15:0]  doutv;
  wire [4:0][15:0]  rdc, wrc, erc;
  wire [4:0]        pe;

  assign if_fix.slave_en  = en && (sel == 3'd0);
  assign if_zero.slave_en = en && (sel == 3'd1);
  assign if_win.slave_en  = en && (sel == 3'd2);
  assign if_rnd.slave_en  = en && (sel == 3'd3);
  assign if_pv.slave_en   = en && (sel == 3'd4);
  assign if_fix.slave_addr  = addr; assign if_fix.slave_wen  = wen; assign if_fix.slave_din  = din;
  assign if_zero.slave_addr = addr; assign if_zero.slave_wen = wen; assign if_zero.slave_din = din;
  assign if_win.slave_addr  = addr; assign if_win.slave_wen  = wen; assign if_win.slave_din  = din;
  assign if_rnd.slave_addr  = addr; assign if_rnd.slave_wen  = wen; assign if_rnd.slave_din  = din;
  assign if_pv.slave_addr   = addr; assign if_pv.slave_wen   = wen; assign if_pv.slave_din   = din;
  assign rdy   = {if_pv.slave_ready, if_rnd.slave_ready, if_win.slave_ready, if_zero.slave_ready, if_fix.slave_ready};
  assign rsp   = {if_pv.slave_resp, if_rnd.slave_resp, if_win.slave_resp, if_zero.slave_resp, if_fix.slave_resp};
  assign doutv = {if_pv.slave_dout, if_rnd.slave_dout, if_win.slave_dout, if_zero.slave_dout, if_fix.slave_dout};

  dma_slave_model #(.WAIT_MODE(0), .WAIT_CYCLES(2)) u_fix (
    .clk(clk), .reset_n(reset_n), .bus(if_fix),
    .rd_cnt(rdc[0]), .wr_cnt(wrc[0]), .err_cnt(erc[0]), .proto_err(pe[0]));
  dma_slave_model #(.WAIT_MODE(0), .WAIT_CYCLES(0)) u_zero (
    .clk(clk), .reset_n(reset_n), .bus(if_zero),
    .rd_cnt(rdc[1]), .wr_cnt(wrc[1]), .err_cnt(erc[1]), .proto_err(pe[1]));
  dma_slave_model #(.BASE_ADDR(16'h0100), .DEPTH(256)) u_win (
    .clk(clk), .reset_n(reset_n), .bus(if_win),
    .rd_cnt(rdc[2]), .wr_cnt(wrc[2]), .err_cnt(erc[2]), .proto_err(pe[2]));
  dma_slave_model #(.WAIT_MODE(1), .MAX_WAIT(7), .LFSR_SEED(16'hACE1)) u_rnd (
    .clk(clk), .reset_n(reset_n), .bus(if_rnd),
    .rd_cnt(rdc[3]), .wr_cnt(wrc[3]), .err_cnt(erc[3]), .proto_err(pe[3]));
  dma_slave_model #(.WAIT_MODE(0), .WAIT_CYCLES(4)) u_pv (
    .clk(clk), .reset_n(reset_n), .bus(if_pv),
    .rd_cnt(rdc[4]), .wr_cnt(wrc[4]), .err_cnt(erc[4]), .proto_err(pe[4]));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transfer starting in IDLE; latency counts clock edges until ready is seen.
  task automatic xfer(input logic [2:0] s, input logic [1:0] w, input logic [15:0] a,
                      input logic [15:0] d, input bit hold,
                      output int lat, output logic [15:0] rd, output logic rs);
    sel = s; addr = a; wen = w; din = d; en = 1'b1; lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rdy[s] && lat < 64);
    if (!rdy[s]) begin
      checks++; failures++;
      $error("FAIL xfer_timeout observed=no_ready expected=ready");
    end
    rd = doutv[s]; rs = rsp[s];
    en = hold;
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  int          lat, pulses, exp_lat;
  logic [15:0] rd, ref_lfsr, pv_dout;
  logic        rs;

  initial begin
    reset_n = 1'b0; en = 1'b0; sel = '0; addr = '0; wen = '0; din = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 16'(rdy), 16'h0);
    check("rst_dout", doutv[0], 16'h0);
    check("rst_rdcnt", rdc[0], 16'h0);
    check("rst_proto", 16'(pe), 16'h0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Fixed two-wait read
    xfer(3'd0, 2'b00, 16'h0005, 16'h0, 1'b0, lat, rd, rs);
    check("fix_lat", 16'(lat), 16'd3);
    check("fix_dout", rd, 16'h0005);
    check("fix_resp", 16'(rs), 16'h0);
    check("fix_rdcnt", rdc[0], 16'd1);

    // Byte-lane writes
    xfer(3'd1, 2'b01, 16'h0003, 16'hBEEF, 1'b0, lat, rd, rs);
    check("bl_wr_lat", 16'(lat), 16'd1);
    check("bl_wr_dout", rd, 16'h0);
    xfer(3'd1, 2'b00, 16'h0003, 16'h0, 1'b0, lat, rd, rs);
    check("bl_rd_lo", rd, 16'h00EF);
    xfer(3'd1, 2'b10, 16'h0003, 16'h12FF, 1'b0, lat, rd, rs);
    xfer(3'd1, 2'b00, 16'h0003, 16'h0, 1'b0, lat, rd, rs);
    check("bl_rd_hi", rd, 16'h12EF);
    check("bl_wrcnt", wrc[1], 16'd2);
    check("bl_rdcnt", rdc[1], 16'd2);

    // Address window with error responses
    xfer(3'd2, 2'b00, 16'h00FF, 16'h0, 1'b0, lat, rd, rs);
    check("win_lo_resp", 16'(rs), 16'h1);
    check("win_lo_dout", rd, 16'h0);
    xfer(3'd2, 2'b11, 16'h0200, 16'h1234, 1'b0, lat, rd, rs);
    check("win_hi_resp", 16'(rs), 16'h1);
    check("win_hi_dout", rd, 16'h0);
    check("win_errcnt", erc[2], 16'd2);
    xfer(3'd2, 2'b00, 16'h01FF, 16'h0, 1'b0, lat, rd, rs);
    check("win_top_resp", 16'(rs), 16'h0);
    check("win_top_dout", rd, 16'h01FF);
    xfer(3'd2, 2'b00, 16'hFFFF, 16'h0, 1'b0, lat, rd, rs);
    check("win_ffff_resp", 16'(rs), 16'h1);
    xfer(3'd2, 2'b00, 16'h0100, 16'h0, 1'b0, lat, rd, rs);
    check("win_base_dout", rd, 16'h0100);
    check("win_errcnt3", erc[2], 16'd3);
    check("win_wrcnt", wrc[2], 16'd0);

    // LFSR-driven waits, back-to-back with en held
    ref_lfsr = 16'hACE1;
    for (int i = 0; i < 100; i++) begin
      exp_lat = 1 + int'(ref_lfsr[2:0]);
      ref_lfsr = lfsr_step(ref_lfsr);
      xfer(3'd3, 2'b00, 16'(i), 16'h0, 1'b1, lat, rd, rs);
      check("rnd_lat", 16'(lat), 16'(exp_lat));
    end
    en = 1'b0;
    check("rnd_last_dout", rd, 16'h0063);
    check("rnd_rdcnt", rdc[3], 16'd100);

    // en dropped in the second WAIT cycle
    sel = 3'd4; addr = 16'h0010; wen = 2'b00; en = 1'b1;
    @(posedge clk); #1;
    check("pv_pre", 16'(pe[4]), 16'h0);
    @(posedge clk); #1;
    en = 1'b0;
    pulses = 0; pv_dout = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rdy[4]) begin pulses++; pv_dout = doutv[4]; end
    end
    check("pv_pulses", 16'(pulses), 16'd1);
    check("pv_dout", pv_dout, 16'h0010);
    check("pv_flag", 16'(pe[4]), 16'h1);
    xfer(3'd4, 2'b00, 16'h0011, 16'h0, 1'b0, lat, rd, rs);
    check("pv_next_lat", 16'(lat), 16'd5);
    check("pv_sticky", 16'(pe[4]), 16'h1);
    check("pv_rdcnt", rdc[4], 16'd2);

    // Reset during a write's WAIT phase
    sel = 3'd0; addr = 16'h0007; wen = 2'b11; din = 16'hDEAD; en = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0; en = 1'b0;
    #1;
    check("mrst_ready", 16'(rdy), 16'h0);
    check("mrst_rdcnt", rdc[0], 16'h0);
    check("mrst_errcnt", erc[2], 16'h0);
    check("mrst_rnd_cnt", rdc[3], 16'h0);
    check("mrst_proto", 16'(pe[4]), 16'h0);
    @(negedge clk) reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rdy[0]) pulses++;
    end
    check("mrst_no_ready", 16'(pulses), 16'd0);
    xfer(3'd0, 2'b00, 16'h0007, 16'h0, 1'b0, lat, rd, rs);
    check("mrst_old_data", rd, 16'h0007);
    check("mrst_wrcnt", wrc[0], 16'd0);
    xfer(3'd1, 2'b00, 16'h0003, 16'h0, 1'b0, lat, rd, rs);
    check("mem_kept", rd, 16'h12EF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
